// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and receiver.
//   OVERSAMPLE   : baud ticks per bit period (the baud strobe runs at 16x baud)
//   uart_state_t : frame state encoding for the serial FSMs
package uart_pkg;

    localparam int OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

endpackage

// File: rtl/uart_tx.sv
// uart_tx: serialises one SIZEDATA-bit word onto the UART line:
// start bit, data LSB first, optional even parity, then stop bit(s).
// The FSM advances only on i_tick cycles (16x baud strobe).
//
// Optional feature: define UART_TX_PARITY_EN to insert a 16-tick even
// parity bit (over the latched word) between the data and stop bits.
//
// Parameters:
//   SIZEDATA    data bits per frame
//   SB_TICK     ticks in the stop period (16 = 1 stop bit, 32 = 2)
// Ports:
//   i_clk       system clock, rising edge
//   i_reset_n   asynchronous active-low reset
//   i_tick      baud strobe, one i_clk wide
//   i_tx_start  send request, only sampled while idle
//   i_tx_data   word to send, latched when the request is accepted
//   o_tx        serial line, idles high
//   o_tx_busy   high from acceptance until the frame ends
//   o_tx_done   one-cycle pulse at frame end
module uart_tx
    import uart_pkg::*;
#(
    parameter int SIZEDATA = 8,
    parameter int SB_TICK  = 16
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic                i_tick,
    input  logic                i_tx_start,
    input  logic [SIZEDATA-1:0] i_tx_data,
    output logic                o_tx,
    output logic                o_tx_busy,
    output logic                o_tx_done
);

    localparam int TW = $clog2(SB_TICK);
    localparam int BW = $clog2(SIZEDATA);

    localparam logic [TW-1:0] BIT_TICK_LAST  = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] STOP_TICK_LAST = TW'(SB_TICK - 1);
    localparam logic [BW-1:0] BIT_LAST       = BW'(SIZEDATA - 1);

    uart_state_t         state_q,  state_next;
    logic [TW-1:0]       tick_q,   tick_next;
    logic [BW-1:0]       bit_q,    bit_next;
    logic [SIZEDATA-1:0] shreg_q,  shreg_next;
    logic                tx_next;
    logic                busy_next;
    logic                done_next;
`ifdef UART_TX_PARITY_EN
    // The shift register is consumed during DATA, so parity is captured
    // from the word at acceptance time.
    logic                parity_q, parity_next;
`endif

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= ST_IDLE;
            tick_q    <= '0;
            bit_q     <= '0;
            shreg_q   <= '0;
            o_tx      <= 1'b1;
            o_tx_busy <= 1'b0;
            o_tx_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_next;
            tick_q    <= tick_next;
            bit_q     <= bit_next;
            shreg_q   <= shreg_next;
            o_tx      <= tx_next;
            o_tx_busy <= busy_next;
            o_tx_done <= done_next;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_next;
`endif
        end
    end

    always_comb begin
        state_next  = state_q;
        tick_next   = tick_q;
        bit_next    = bit_q;
        shreg_next  = shreg_q;
        done_next   = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_next = parity_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (i_tx_start) begin
                    state_next  = ST_START;
                    tick_next   = '0;
                    shreg_next  = i_tx_data;
`ifdef UART_TX_PARITY_EN
                    parity_next = ^i_tx_data;
`endif
                end
            end
            ST_START: begin
                if (i_tick) begin
                    if (tick_q == BIT_TICK_LAST) begin
                        state_next = ST_DATA;
                        tick_next  = '0;
                        bit_next   = '0;
                    end else begin
                        tick_next = tick_q + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (i_tick) begin
                    if (tick_q == BIT_TICK_LAST) begin
                        tick_next  = '0;
                        shreg_next = shreg_q >> 1;
                        if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                            state_next = ST_PARITY;
`else
                            state_next = ST_STOP;
`endif
                        end else begin
                            bit_next = bit_q + 1'b1;
                        end
                    end else begin
                        tick_next = tick_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (i_tick) begin
                    if (tick_q == BIT_TICK_LAST) begin
                        state_next = ST_STOP;
                        tick_next  = '0;
                    end else begin
                        tick_next = tick_q + 1'b1;
                    end
                end
            end
`endif
            ST_STOP: begin
                if (i_tick) begin
                    if (tick_q == STOP_TICK_LAST) begin
                        state_next = ST_IDLE;
                        tick_next  = '0;
                        done_next  = 1'b1;
                    end else begin
                        tick_next = tick_q + 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
                tick_next  = '0;
            end
        endcase
    end

    // Outputs are registered: their next values follow the next state so
    // the line changes in the same cycle the FSM does.
    always_comb begin
        tx_next   = 1'b1;
        busy_next = (state_next != ST_IDLE);
        unique case (state_next)
            ST_START:  tx_next = 1'b0;
            ST_DATA:   tx_next = shreg_next[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_next = parity_next;
`endif
            default:   tx_next = 1'b1;
        endcase
    end

endmodule
